// File: rtl/load_store_unit.sv
// Load/store unit: byte-addressed requests to a word-wide d_mem port, with sub-word RMW stores and extended loads.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned requests respond with an error instead of being aligned).
module load_store_unit #(
    parameter int BYTE_ADDR = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_Address,
    output logic [31:0] mem_WriteData,
    input  logic [31:0] mem_ReadData,
    output logic        mem_MemWrite,
    output logic        mem_MemRead
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rword_q, rword_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        err_q, err_d;
`endif

    function automatic logic op_is_word(input logic [2:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic op_is_half(input logic [2:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [15:0] half;
        logic [7:0]  bsel;
        half = lane[1] ? word[31:16] : word[15:0];
        case (lane)
            2'd0:    bsel = word[7:0];
            2'd1:    bsel = word[15:8];
            2'd2:    bsel = word[23:16];
            default: bsel = word[31:24];
        endcase
        case (op)
            OP_LH:   return {{16{half[15]}}, half};
            OP_LHU:  return {16'h0000, half};
            OP_LB:   return {{24{bsel[7]}}, bsel};
            OP_LBU:  return {24'h000000, bsel};
            default: return word;
        endcase
    endfunction

    // Replace one lane of the word read back from memory with the store data
    function automatic logic [31:0] store_merge(input logic [2:0] op, input logic [1:0] lane,
                                                input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] res;
        res = word;
        if (op == OP_SH) begin
            if (lane[1]) res[31:16] = wd[15:0];
            else         res[15:0]  = wd[15:0];
        end else begin
            case (lane)
                2'd0:    res[7:0]   = wd[7:0];
                2'd1:    res[15:8]  = wd[7:0];
                2'd2:    res[23:16] = wd[7:0];
                default: res[31:24] = wd[7:0];
            endcase
        end
        return res;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        op_q    <= op_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rword_q <= rword_d;
`ifdef LSU_MISALIGN_TRAP_EN
        err_q   <= err_d;
`endif
    end

    always_comb begin
        logic misaligned;
        state_d    = state_q;
        misaligned = (op_is_half(req_op) && req_addr[0]) ||
                     (op_is_word(req_op) && (req_addr[1:0] != 2'b00));
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned)            state_d = S_RESP;
                    else if (req_op == OP_SW)  state_d = S_WR;
                    else                       state_d = S_RD;
`else
                    state_d = (req_op == OP_SW) ? S_WR : S_RD;
`endif
                end
            end
            S_RD:    state_d = (op_q <= OP_LBU) ? S_RESP : S_WR;
            S_WR:    state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rword_d = rword_q;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d   = err_q;
`endif
        if (state_q == S_IDLE && req_valid) begin
            op_d    = req_op;
            wdata_d = req_wdata;
            addr_d  = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
            err_d   = (op_is_half(req_op) && req_addr[0]) ||
                      (op_is_word(req_op) && (req_addr[1:0] != 2'b00));
`else
            if (op_is_word(req_op))      addr_d[1:0] = 2'b00;
            else if (op_is_half(req_op)) addr_d[0]   = 1'b0;
`endif
        end
        if (state_q == S_RD) rword_d = mem_ReadData;
    end

    // Outputs decode from state and latched registers only
    always_comb begin
        logic [31:0] addr_fmt;
        logic        load_ok;
        addr_fmt = (BYTE_ADDR != 0) ? {addr_q[31:2], 2'b00} : {2'b00, addr_q[31:2]};
        load_ok  = (op_q <= OP_LBU);
`ifdef LSU_MISALIGN_TRAP_EN
        load_ok  = load_ok && !err_q;
        resp_err = (state_q == S_RESP) && err_q;
`else
        resp_err = 1'b0;
`endif
        req_ready     = (state_q == S_IDLE);
        resp_valid    = (state_q == S_RESP);
        mem_MemRead   = (state_q == S_RD);
        mem_MemWrite  = (state_q == S_WR);
        mem_Address   = (state_q == S_RD || state_q == S_WR) ? addr_fmt : 32'h0;
        mem_WriteData = 32'h0;
        if (state_q == S_WR)
            mem_WriteData = (op_q == OP_SW) ? wdata_q
                                            : store_merge(op_q, addr_q[1:0], rword_q, wdata_q);
        resp_rdata = ((state_q == S_RESP) && load_ok)
                     ? load_extend(op_q, addr_q[1:0], rword_q) : 32'h0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table-driven requests against a small word memory, scoreboard on responses.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_Address;
    logic [31:0] mem_WriteData;
    logic [31:0] mem_ReadData;
    logic        mem_MemWrite;
    logic        mem_MemRead;

    load_store_unit #(.BYTE_ADDR(0)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_Address(mem_Address), .mem_WriteData(mem_WriteData), .mem_ReadData(mem_ReadData),
        .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:15];
    assign mem_ReadData = mem[mem_Address[3:0]];
    always @(posedge clock) if (mem_MemWrite) mem[mem_Address[3:0]] <= mem_WriteData;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        rd;
        logic        wr;
        logic [31:0] maddr;
        logic [31:0] mwdata;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   fails = 0;
    int   resp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every response must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (!reset && resp_valid) begin
            exp_t e;
            resp_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int   lat;
        int   guard;
        logic saw_rd, saw_wr, done;
        exp_t e;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        e.rdata   = v.rdata;
        e.err     = v.err;
        sb.push_back(e);
        @(posedge clock);
        lat = 0; saw_rd = 1'b0; saw_wr = 1'b0; done = 1'b0;
        while (!done && lat < 8) begin
            @(negedge clock);
            lat++;
            req_valid = 1'b0;
            req_op    = 3'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            if (mem_MemRead) begin
                saw_rd = 1'b1;
                check($sformatf("rd_addr[%0d]", idx), mem_Address, v.maddr);
            end
            if (mem_MemWrite) begin
                saw_wr = 1'b1;
                check($sformatf("wr_addr[%0d]", idx), mem_Address, v.maddr);
                check($sformatf("wr_data[%0d]", idx), mem_WriteData, v.mwdata);
            end
            check($sformatf("strobe_excl[%0d]", idx), {31'd0, mem_MemRead & mem_MemWrite}, 32'd0);
            check($sformatf("ready_busy[%0d]", idx), {31'd0, req_ready}, 32'd0);
            if (resp_valid) done = 1'b1;
        end
        check($sformatf("latency[%0d]", idx), lat, v.lat);
        check($sformatf("saw_rd[%0d]", idx), {31'd0, saw_rd}, {31'd0, v.rd});
        check($sformatf("saw_wr[%0d]", idx), {31'd0, saw_wr}, {31'd0, v.wr});
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int accepts;
        int start_resp;
        vec_t rv;

        //            op    addr         wdata          rdata          err  lat rd wr maddr mwdata
        vecs.push_back('{3'd5, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1'b0, 1'b1, 32'd4, 32'hDEADBEEF});
        vecs.push_back('{3'd0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1'b1, 1'b0, 32'd4, 32'h0});
        vecs.push_back('{3'd5, 32'h10, 32'h123480F0, 32'h0,        1'b0, 2, 1'b0, 1'b1, 32'd4, 32'h123480F0});
        vecs.push_back('{3'd3, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0, 2, 1'b1, 1'b0, 32'd4, 32'h0});
        vecs.push_back('{3'd4, 32'h11, 32'h0,        32'h00000080, 1'b0, 2, 1'b1, 1'b0, 32'd4, 32'h0});
        vecs.push_back('{3'd1, 32'h12, 32'h0,        32'h00001234, 1'b0, 2, 1'b1, 1'b0, 32'd4, 32'h0});
        vecs.push_back('{3'd2, 32'h10, 32'h0,        32'h000080F0, 1'b0, 2, 1'b1, 1'b0, 32'd4, 32'h0});
        vecs.push_back('{3'd1, 32'h10, 32'h0,        32'hFFFF80F0, 1'b0, 2, 1'b1, 1'b0, 32'd4, 32'h0});
        vecs.push_back('{3'd7, 32'h13, 32'h555555AB, 32'h0,        1'b0, 3, 1'b1, 1'b1, 32'd4, 32'hAB3480F0});
        vecs.push_back('{3'd0, 32'h10, 32'h0,        32'hAB3480F0, 1'b0, 2, 1'b1, 1'b0, 32'd4, 32'h0});
        vecs.push_back('{3'd6, 32'h12, 32'h1234CAFE, 32'h0,        1'b0, 3, 1'b1, 1'b1, 32'd4, 32'hCAFE80F0});
        vecs.push_back('{3'd4, 32'h13, 32'h0,        32'h000000CA, 1'b0, 2, 1'b1, 1'b0, 32'd4, 32'h0});
        vecs.push_back('{3'd3, 32'h10, 32'h0,        32'hFFFFFFF0, 1'b0, 2, 1'b1, 1'b0, 32'd4, 32'h0});
        vecs.push_back('{3'd3, 32'h12, 32'h0,        32'hFFFFFFFE, 1'b0, 2, 1'b1, 1'b0, 32'd4, 32'h0});
        vecs.push_back('{3'd5, 32'h04, 32'h11112222, 32'h0,        1'b0, 2, 1'b0, 1'b1, 32'd1, 32'h11112222});
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{3'd0, 32'h06, 32'h0,        32'h0,        1'b1, 1, 1'b0, 1'b0, 32'd0, 32'h0});
        vecs.push_back('{3'd6, 32'h05, 32'h0000BEEF, 32'h0,        1'b1, 1, 1'b0, 1'b0, 32'd0, 32'h0});
        vecs.push_back('{3'd0, 32'h04, 32'h0,        32'h11112222, 1'b0, 2, 1'b1, 1'b0, 32'd1, 32'h0});
`else
        vecs.push_back('{3'd0, 32'h06, 32'h0,        32'h11112222, 1'b0, 2, 1'b1, 1'b0, 32'd1, 32'h0});
        vecs.push_back('{3'd6, 32'h05, 32'h0000BEEF, 32'h0,        1'b0, 3, 1'b1, 1'b1, 32'd1, 32'h1111BEEF});
        vecs.push_back('{3'd0, 32'h04, 32'h0,        32'h1111BEEF, 1'b0, 2, 1'b1, 1'b0, 32'd1, 32'h0});
`endif

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_mem_read", {31'd0, mem_MemRead}, 32'd0);
        check("rst_mem_write", {31'd0, mem_MemWrite}, 32'd0);
        check("rst_mem_addr", mem_Address, 32'h0);
        check("rst_mem_wdata", mem_WriteData, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset during the RD cycle of an SH: request is dropped, nothing written
        req_valid = 1'b1;
        req_op    = 3'd6;
        req_addr  = 32'h10;
        req_wdata = 32'h00007777;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("abort_in_rd", {31'd0, mem_MemRead}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        check("abort_no_write", {31'd0, mem_MemWrite}, 32'd0);
        repeat (3) begin
            @(negedge clock);
            check("abort_idle_write", {31'd0, mem_MemWrite}, 32'd0);
        end
        rv = '{3'd0, 32'h10, 32'h0, 32'hCAFE80F0, 1'b0, 2, 1'b1, 1'b0, 32'd4, 32'h0};
        run_vec(rv, 100);

        // Back-to-back: req_valid held high, alternating SW/LW to word 8
        accepts    = 0;
        start_resp = resp_cnt;
        req_valid  = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (req_ready) begin
                exp_t e;
                if (accepts % 2 == 0) begin
                    req_op    = 3'd5;
                    req_wdata = 32'h100 + accepts;
                    e.rdata   = 32'h0;
                end else begin
                    req_op    = 3'd0;
                    req_wdata = $urandom;
                    e.rdata   = 32'h100 + accepts - 1;
                end
                req_addr = 32'h20;
                e.err    = 1'b0;
                sb.push_back(e);
                accepts++;
            end else begin
                check("b2b_ready_low", {31'd0, req_ready},
                      {31'd0, !(mem_MemRead | mem_MemWrite | resp_valid)});
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clock);
        check("b2b_resp_count", resp_cnt - start_resp, accepts);
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
